// File: rtl/regfile_mp.sv
// ============================================================================
// Module  : regfile_mp
// Brief   : Multi-port integer register file with pending-write scoreboard.
//           Optional same-cycle write-to-read bypass under REGFILE_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    r_sel,
  output logic [NRD*XLEN-1:0]  r_data,
  output logic [NRD-1:0]       r_pend,
  input  logic [NWR-1:0]       w_en,
  input  logic [NWR*AW-1:0]    w_sel,
  input  logic [NWR*XLEN-1:0]  w_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_sel,
  input  logic [AW-1:0]        dbg_reg_sel,
  output logic [XLEN-1:0]      dbg_reg_data
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;

  // Ascending port order lets the highest-index port overwrite lower ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_en[j] && (w_sel[j*AW +: AW] != '0)) begin
          regs[w_sel[j*AW +: AW]] <= w_data[j*XLEN +: XLEN];
          pend[w_sel[j*AW +: AW]] <= 1'b0;
        end
      end
      if (sb_set && (sb_sel != '0)) begin
        pend[sb_sel] <= 1'b1;
      end
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   sel;
      logic [XLEN-1:0] data;
      logic            pnd;

      assign sel = r_sel[k*AW +: AW];

      always_comb begin
        data = '0;
        pnd  = 1'b0;
        if (sel != '0) begin
          data = regs[sel];
          pnd  = pend[sel];
`ifdef REGFILE_BYPASS_EN
          for (int j = 0; j < NWR; j++) begin
            if (w_en[j] && (w_sel[j*AW +: AW] == sel)) begin
              data = w_data[j*XLEN +: XLEN];
              if (!(sb_set && (sb_sel == sel))) begin
                pnd = 1'b0;
              end
            end
          end
`endif
        end
      end

      assign r_data[k*XLEN +: XLEN] = data;
      assign r_pend[k]              = pnd;
    end
  endgenerate

  assign dbg_reg_data = (dbg_reg_sel == '0) ? '0 : regs[dbg_reg_sel];

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module  : tb_regfile_mp
// Brief   : Self-checking bench for regfile_mp against an array-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   r_sel;
  logic [NRD*XLEN-1:0] r_data;
  logic [NRD-1:0]      r_pend;
  logic [NWR-1:0]      w_en;
  logic [NWR*AW-1:0]   w_sel;
  logic [NWR*XLEN-1:0] w_data;
  logic                sb_set;
  logic [AW-1:0]       sb_sel;
  logic [AW-1:0]       dbg_reg_sel;
  logic [XLEN-1:0]     dbg_reg_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [XLEN-1:0] mem [NREGS];
  bit              pend_m [NREGS];
  bit              model_valid = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r_sel        (r_sel),
    .r_data       (r_data),
    .r_pend       (r_pend),
    .w_en         (w_en),
    .w_sel        (w_sel),
    .w_data       (w_data),
    .sb_set       (sb_set),
    .sb_sel       (sb_sel),
    .dbg_reg_sel  (dbg_reg_sel),
    .dbg_reg_data (dbg_reg_data)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Highest-index enabled write port aiming at s, or -1 if none.
  function automatic int winner(input logic [AW-1:0] s);
    int w = -1;
    for (int j = 0; j < NWR; j++)
      if (w_en[j] && w_sel[j*AW +: AW] == s) w = j;
    return w;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] s);
    if (s == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (winner(s) >= 0) return w_data[winner(s)*XLEN +: XLEN];
`endif
    return mem[s];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] s);
    if (s == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (winner(s) >= 0 && !(sb_set && sb_sel == s)) return 1'b0;
`endif
    return pend_m[s];
  endfunction

  // Check current outputs against the model, clock once, advance the model.
  task automatic step();
    #1;
    if (model_valid) begin
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rdata%0d", k), r_data[k*XLEN +: XLEN], exp_data(r_sel[k*AW +: AW]));
        check($sformatf("rpend%0d", k), {31'd0, r_pend[k]}, {31'd0, exp_pend(r_sel[k*AW +: AW])});
      end
      check("dbg", dbg_reg_data, (dbg_reg_sel == 0) ? '0 : mem[dbg_reg_sel]);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i]    = '0;
        pend_m[i] = 1'b0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        int w = winner(AW'(i));
        if (w >= 0) begin
          mem[i]    = w_data[w*XLEN +: XLEN];
          pend_m[i] = 1'b0;
        end
        if (sb_set && sb_sel == AW'(i)) pend_m[i] = 1'b1;
      end
    end
    model_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n  = 1'b1;
    w_en   = '0;
    sb_set = 1'b0;
  endtask

  function automatic logic [AW-1:0] rsel();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS-1));
  endfunction

  task automatic randomize_inputs(input bit allow_reset);
    rst_n = !(allow_reset && $urandom_range(0, 39) == 0);
    for (int j = 0; j < NWR; j++) begin
      w_en[j]                = 1'($urandom_range(0, 1));
      w_sel[j*AW +: AW]      = rsel();
      w_data[j*XLEN +: XLEN] = $urandom;
    end
    for (int k = 0; k < NRD; k++) r_sel[k*AW +: AW] = rsel();
    sb_set      = 1'($urandom_range(0, 2) == 0);
    sb_sel      = rsel();
    dbg_reg_sel = rsel();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    r_sel = '0; w_sel = '0; w_data = '0; sb_sel = '0; dbg_reg_sel = '0;
    @(negedge clk);
    step();

    // Plain write, visible next cycle
    idle(); w_en = 2'b01; w_sel[0 +: AW] = 5; w_data[0 +: XLEN] = 32'hDEADBEEF;
    step();
    idle(); r_sel[0 +: AW] = 5;
    #1 check("t2_read", r_data[0 +: XLEN], 32'hDEADBEEF);
    step();

    // Collision: port 1 wins
    idle(); w_en = 2'b11; w_sel = {AW'(7), AW'(7)}; w_data = {32'h2222, 32'h1111};
    step();
    idle(); r_sel[0 +: AW] = 7;
    #1 check("t3_collide", r_data[0 +: XLEN], 32'h2222);
    step();

    // Register 0 is hardwired
    idle(); w_en = 2'b01; w_sel[0 +: AW] = 0; w_data[0 +: XLEN] = 32'hFFFFFFFF; sb_set = 1'b1; sb_sel = 0;
    step();
    idle(); r_sel[0 +: AW] = 0;
    #1 check("t4_r0_data", r_data[0 +: XLEN], 32'h0);
    check("t4_r0_pend", {31'd0, r_pend[0]}, 32'd0);
    step();

    // Scoreboard: set, set-beats-clear, clear
    idle(); sb_set = 1'b1; sb_sel = 9;
    step();
    idle(); r_sel[0 +: AW] = 9;
    #1 check("t5_set", {31'd0, r_pend[0]}, 32'd1);
    w_en = 2'b01; w_sel[0 +: AW] = 9; w_data[0 +: XLEN] = 32'h99; sb_set = 1'b1; sb_sel = 9;
    step();
    idle();
    #1 check("t5_setwins", {31'd0, r_pend[0]}, 32'd1);
    w_en = 2'b01; w_sel[0 +: AW] = 9;
    step();
    idle();
    #1 check("t5_clear", {31'd0, r_pend[0]}, 32'd0);
    step();

    // Same-cycle write and read of reg 3
    idle(); w_en = 2'b01; w_sel[0 +: AW] = 3; w_data[0 +: XLEN] = 32'h1234;
    step();
    idle(); w_en = 2'b01; w_sel[0 +: AW] = 3; w_data[0 +: XLEN] = 32'hA5A5; r_sel[0 +: AW] = 3;
`ifdef REGFILE_BYPASS_EN
    #1 check("t6_same", r_data[0 +: XLEN], 32'hA5A5);
`else
    #1 check("t6_same", r_data[0 +: XLEN], 32'h1234);
`endif
    step();
    idle();
    #1 check("t6_next", r_data[0 +: XLEN], 32'hA5A5);
    step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      randomize_inputs(1'b1);
      step();
    end

    // Reset after random writes clears everything
    for (int n = 0; n < 20; n++) begin
      randomize_inputs(1'b0);
      sb_set = 1'b1;
      step();
    end
    randomize_inputs(1'b0);
    rst_n = 1'b0;
    step();
    idle();
    for (int i = 0; i < NREGS; i++) begin
      r_sel = {AW'(i), AW'(i)};
      dbg_reg_sel = AW'(i);
      #1;
      check("t1_data0", r_data[0 +: XLEN], 32'h0);
      check("t1_data1", r_data[XLEN +: XLEN], 32'h0);
      check("t1_pend", {30'd0, r_pend}, 32'd0);
      check("t1_dbg", dbg_reg_data, 32'h0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
